placement_controller: RTL and testbench

Turn and cursor sequencer for the board-game datapath. It converts edge-detected direction and confirm buttons into cursor-update commands (`i_next`, `j_next`, `enable`) for the cursor position register, and reads the current position back as `i_actual`/`j_actual`. It also validates placement against the board's occupancy, alternates the active player and enforces a per-turn timeout.

---
 rtl/placement_controller_if.sv | 42 ++++
 rtl/placement_controller.sv | 191 +++++++++++++++++++
 tb/tb_placement_controller.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/placement_controller_if.sv
// Placement controller bus: game control, buttons, cursor readback,
// cursor commands and placement results.
interface placement_controller_if;
  logic       start;
  logic       game_over;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       btn_confirm;
  logic [2:0] i_actual;
  logic [2:0] j_actual;
  logic       cell_occupied;
  logic [2:0] i_next;
  logic [2:0] j_next;
  logic       enable;
  logic       place_valid;
  logic [2:0] place_i;
  logic [2:0] place_j;
  logic       player;
  logic       place_error;
  logic       turn_timeout;
  logic [1:0] state;

  modport master (
    output start, game_over,
    output btn_up, btn_down, btn_left, btn_right, btn_confirm,
    output i_actual, j_actual, cell_occupied,
    input  i_next, j_next, enable,
    input  place_valid, place_i, place_j,
    input  player, place_error, turn_timeout, state
  );

  modport slave (
    input  start, game_over,
    input  btn_up, btn_down, btn_left, btn_right, btn_confirm,
    input  i_actual, j_actual, cell_occupied,
    output i_next, j_next, enable,
    output place_valid, place_i, place_j,
    output player, place_error, turn_timeout, state
  );
endinterface

// File: rtl/placement_controller.sv
// Turn and cursor sequencer: button edges to cursor commands,
// placement validation, player alternation and turn timeout.
module placement_controller #(
  parameter int BOARD_N        = 6,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input logic                   clk,
  input logic                   rst,
  placement_controller_if.slave pc_if
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COLOC = 2'd1,
    CHECK = 2'd2,
    PLACE = 2'd3
  } state_e;

  localparam int          TW    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]  MAXC  = 3'(BOARD_N - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          player_q, player_d;
  logic [2:0]    i_next_q, i_next_d;
  logic [2:0]    j_next_q, j_next_d;
  logic          enable_q, enable_d;
  logic          pvalid_q, pvalid_d;
  logic          perr_q, perr_d;
  logic          tout_q, tout_d;
  logic [2:0]    place_i_q, place_i_d;
  logic [2:0]    place_j_q, place_j_d;
  logic [4:0]    btn_prev_q;

  logic [4:0] btn;
  logic [4:0] ev;
  logic [4:0] act;
  logic       oor;

  function automatic logic [2:0] dec_w(input logic [2:0] v);
    return (v == 3'd0) ? MAXC : v - 3'd1;
  endfunction

  function automatic logic [2:0] inc_w(input logic [2:0] v);
    return (v == MAXC) ? 3'd0 : v + 3'd1;
  endfunction

  assign btn = {pc_if.btn_right, pc_if.btn_left, pc_if.btn_down,
                pc_if.btn_up, pc_if.btn_confirm};
  assign ev  = btn & ~btn_prev_q;
  // lowest set bit wins: confirm > up > down > left > right
  assign act = ev & (~ev + 5'd1);
  assign oor = ({1'b0, pc_if.i_actual} >= 4'(BOARD_N)) ||
               ({1'b0, pc_if.j_actual} >= 4'(BOARD_N));

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    player_d  = player_q;
    i_next_d  = i_next_q;
    j_next_d  = j_next_q;
    enable_d  = 1'b0;
    pvalid_d  = 1'b0;
    perr_d    = 1'b0;
    tout_d    = 1'b0;
    place_i_d = place_i_q;
    place_j_d = place_j_q;

    if (pc_if.game_over) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pc_if.start) begin
            state_d  = COLOC;
            player_d = 1'b0;
            timer_d  = '0;
            i_next_d = 3'd0;
            j_next_d = 3'd0;
            enable_d = 1'b1;
          end
        end
        COLOC: begin
          timer_d = timer_q + TW'(1);
          if (timer_q == TLAST) begin
            tout_d   = 1'b1;
            player_d = ~player_q;
            timer_d  = '0;
            i_next_d = 3'd0;
            j_next_d = 3'd0;
            enable_d = 1'b1;
          end else begin
            unique case (1'b1)
              act[0]: begin
                place_i_d = pc_if.i_actual;
                place_j_d = pc_if.j_actual;
                state_d   = CHECK;
              end
              act[1]: begin
                i_next_d = dec_w(pc_if.i_actual);
                j_next_d = pc_if.j_actual;
                enable_d = 1'b1;
              end
              act[2]: begin
                i_next_d = inc_w(pc_if.i_actual);
                j_next_d = pc_if.j_actual;
                enable_d = 1'b1;
              end
              act[3]: begin
                i_next_d = pc_if.i_actual;
                j_next_d = dec_w(pc_if.j_actual);
                enable_d = 1'b1;
              end
              act[4]: begin
                i_next_d = pc_if.i_actual;
                j_next_d = inc_w(pc_if.j_actual);
                enable_d = 1'b1;
              end
              default: ;
            endcase
            if (|act[4:1] && oor) begin
              i_next_d = 3'd0;
              j_next_d = 3'd0;
            end
          end
        end
        CHECK: begin
          if (pc_if.cell_occupied) begin
            perr_d  = 1'b1;
            state_d = COLOC;
          end else begin
            pvalid_d = 1'b1;
            state_d  = PLACE;
          end
        end
        PLACE: begin
          player_d = ~player_q;
          timer_d  = '0;
          i_next_d = 3'd0;
          j_next_d = 3'd0;
          enable_d = 1'b1;
          state_d  = COLOC;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      player_q   <= 1'b0;
      i_next_q   <= 3'd0;
      j_next_q   <= 3'd0;
      enable_q   <= 1'b0;
      pvalid_q   <= 1'b0;
      perr_q     <= 1'b0;
      tout_q     <= 1'b0;
      place_i_q  <= 3'd0;
      place_j_q  <= 3'd0;
      btn_prev_q <= 5'd0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      player_q   <= player_d;
      i_next_q   <= i_next_d;
      j_next_q   <= j_next_d;
      enable_q   <= enable_d;
      pvalid_q   <= pvalid_d;
      perr_q     <= perr_d;
      tout_q     <= tout_d;
      place_i_q  <= place_i_d;
      place_j_q  <= place_j_d;
      btn_prev_q <= btn;
    end
  end

  assign pc_if.i_next       = i_next_q;
  assign pc_if.j_next       = j_next_q;
  assign pc_if.enable       = enable_q;
  assign pc_if.place_valid  = pvalid_q;
  assign pc_if.place_i      = place_i_q;
  assign pc_if.place_j      = place_j_q;
  assign pc_if.player       = player_q;
  assign pc_if.place_error  = perr_q;
  assign pc_if.turn_timeout = tout_q;
  assign pc_if.state        = state_q;

endmodule

// File: tb/tb_placement_controller.sv
// Scoreboard bench for placement_controller: expected pulse
// events queued at stimulus time, popped when the DUT pulses.
module tb_placement_controller;

  localparam int N  = 6;
  localparam int TO = 8;

  localparam logic [3:0] K_EN = 4'b0001;
  localparam logic [3:0] K_PV = 4'b0010;
  localparam logic [3:0] K_PE = 4'b0100;
  localparam logic [3:0] K_TO = 4'b1000;

  typedef struct {
    logic [3:0] kind;
    logic [2:0] ni;
    logic [2:0] nj;
    logic [2:0] pi;
    logic [2:0] pj;
    logic       pl;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  placement_controller_if bus ();

  placement_controller #(
    .BOARD_N       (N),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .pc_if(bus)
  );

  always #5 clk = ~clk;

  ev_t sbq[$];
  int  n_vec = 0;
  int  n_err = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push(logic [3:0] k, logic [2:0] ni, logic [2:0] nj,
                      logic [2:0] pi, logic [2:0] pj, logic pl);
    ev_t e;
    e.kind = k;
    e.ni = ni;
    e.nj = nj;
    e.pi = pi;
    e.pj = pj;
    e.pl = pl;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    logic [3:0] k;
    ev_t e;
    k = {bus.turn_timeout, bus.place_error, bus.place_valid, bus.enable};
    if (k != 4'd0) begin
      if (sbq.size() == 0) begin
        check("unexpected_pulse", 32'(k), 32'd0);
      end else begin
        e = sbq.pop_front();
        check("pulse_kind", 32'(k), 32'(e.kind));
        if (e.kind[0]) begin
          check("i_next", 32'(bus.i_next), 32'(e.ni));
          check("j_next", 32'(bus.j_next), 32'(e.nj));
        end
        if (|e.kind[2:1]) begin
          check("place_i", 32'(bus.place_i), 32'(e.pi));
          check("place_j", 32'(bus.place_j), 32'(e.pj));
        end
        check("pulse_player", 32'(bus.player), 32'(e.pl));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    @(negedge clk);
    #1;
    check("pending_events", 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  task automatic restart();
    bus.game_over = 1'b1;
    step();
    check("go_idle", 32'(bus.state), 32'd0);
    bus.game_over = 1'b0;
    bus.start     = 1'b1;
    push(K_EN, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    step();
    check("start_coloc", 32'(bus.state), 32'd1);
    bus.start = 1'b0;
  endtask

  function automatic logic [18:0] outs();
    return {bus.state, bus.i_next, bus.j_next, bus.enable,
            bus.place_valid, bus.place_error, bus.turn_timeout,
            bus.place_i, bus.place_j, bus.player};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, want summary");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start         = 1'b0;
    bus.game_over     = 1'b0;
    bus.btn_up        = 1'b1;
    bus.btn_down      = 1'b0;
    bus.btn_left      = 1'b0;
    bus.btn_right     = 1'b0;
    bus.btn_confirm   = 1'b0;
    bus.i_actual      = 3'd0;
    bus.j_actual      = 3'd0;
    bus.cell_occupied = 1'b0;

    // reset with up held across release: edge lands in IDLE
    #3 rst = 1'b0;
    #1 check("reset_outs", 32'(outs()), 32'd0);
    step();
    step();
    rst = 1'b1;
    step();
    check("held_btn_idle", 32'(bus.state), 32'd0);
    bus.btn_up = 1'b0;
    step();
    drain();

    restart();
    check("start_player", 32'(bus.player), 32'd0);
    drain();

    // wrap moves and back-to-back pulses
    restart();
    bus.btn_up = 1'b1;
    push(K_EN, 3'd5, 3'd0, 3'd0, 3'd0, 1'b0);
    step();
    bus.btn_up = 1'b0;
    step();
    bus.i_actual  = 3'd5;
    bus.j_actual  = 3'd5;
    bus.btn_right = 1'b1;
    push(K_EN, 3'd5, 3'd0, 3'd0, 3'd0, 1'b0);
    step();
    bus.btn_right = 1'b0;
    bus.btn_down  = 1'b1;
    push(K_EN, 3'd0, 3'd5, 3'd0, 3'd0, 1'b0);
    step();
    bus.btn_down = 1'b0;
    bus.btn_left = 1'b1;
    push(K_EN, 3'd5, 3'd4, 3'd0, 3'd0, 1'b0);
    step();
    bus.btn_left = 1'b0;
    step();
    drain();

    // simultaneous up+left, then out-of-range cursor
    restart();
    bus.i_actual = 3'd2;
    bus.j_actual = 3'd2;
    bus.btn_up   = 1'b1;
    bus.btn_left = 1'b1;
    push(K_EN, 3'd1, 3'd2, 3'd0, 3'd0, 1'b0);
    step();
    bus.btn_up   = 1'b0;
    bus.btn_left = 1'b0;
    step();
    bus.i_actual  = 3'd7;
    bus.j_actual  = 3'd1;
    bus.btn_right = 1'b1;
    push(K_EN, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    step();
    bus.btn_right = 1'b0;
    step();
    drain();

    // confirm (with up, confirm wins) on free cell (2,3)
    restart();
    bus.i_actual      = 3'd2;
    bus.j_actual      = 3'd3;
    bus.cell_occupied = 1'b0;
    bus.btn_confirm   = 1'b1;
    bus.btn_up        = 1'b1;
    step();
    check("confirm_check", 32'(bus.state), 32'd2);
    bus.btn_confirm = 1'b0;
    bus.btn_up      = 1'b0;
    push(K_PV, 3'd0, 3'd0, 3'd2, 3'd3, 1'b0);
    step();
    check("place_state", 32'(bus.state), 32'd3);
    push(K_EN, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1);
    step();
    check("after_place", 32'(bus.state), 32'd1);
    check("player_toggled", 32'(bus.player), 32'd1);
    drain();

    // occupied cell: error, timer keeps running from 3
    bus.i_actual      = 3'd1;
    bus.j_actual      = 3'd4;
    bus.cell_occupied = 1'b1;
    step();
    step();
    bus.btn_confirm = 1'b1;
    step();
    check("err_check", 32'(bus.state), 32'd2);
    bus.btn_confirm = 1'b0;
    push(K_PE, 3'd0, 3'd0, 3'd1, 3'd4, 1'b1);
    step();
    check("err_back", 32'(bus.state), 32'd1);
    check("err_player", 32'(bus.player), 32'd1);
    bus.cell_occupied = 1'b0;
    drain();
    repeat (4) step();
    push(K_EN | K_TO, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    step();
    check("err_timeout_state", 32'(bus.state), 32'd1);
    check("place_i_stable", 32'(bus.place_i), 32'd1);
    drain();

    // timeout from entry, confirm on the timeout cycle ignored
    restart();
    bus.i_actual = 3'd3;
    bus.j_actual = 3'd3;
    repeat (7) step();
    bus.btn_confirm = 1'b1;
    push(K_EN | K_TO, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1);
    step();
    check("to_state", 32'(bus.state), 32'd1);
    bus.btn_confirm = 1'b0;
    step();
    check("to_state_hold", 32'(bus.state), 32'd1);
    drain();

    // game_over during CHECK
    restart();
    bus.i_actual    = 3'd0;
    bus.j_actual    = 3'd0;
    bus.btn_confirm = 1'b1;
    step();
    check("go_check", 32'(bus.state), 32'd2);
    bus.btn_confirm = 1'b0;
    bus.game_over   = 1'b1;
    step();
    check("go_abort", 32'(bus.state), 32'd0);
    bus.game_over = 1'b0;
    step();
    check("go_stay_idle", 32'(bus.state), 32'd0);
    drain();

    // async reset in the middle of PLACE
    restart();
    bus.i_actual    = 3'd4;
    bus.j_actual    = 3'd1;
    bus.btn_confirm = 1'b1;
    step();
    bus.btn_confirm = 1'b0;
    push(K_PV, 3'd0, 3'd0, 3'd4, 3'd1, 1'b0);
    step();
    check("rst_in_place", 32'(bus.state), 32'd3);
    @(negedge clk);
    #1;
    check("pv_before_rst", 32'(bus.place_valid), 32'd1);
    rst = 1'b0;
    #1;
    check("rst_async_outs", 32'(outs()), 32'd0);
    check("rst_async_pv", 32'(bus.place_valid), 32'd0);
    step();
    rst = 1'b1;
    step();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
